sort_arbiter: RTL and testbench

- Shares one vector sorter (NUM_ELEMS x DATA_WIDTH, valid/ready in and out) between NUM_REQ requester channels.
- Round-robin grants one requester at a time onto the sorter input.
- Records the requester index of every job the sorter accepts in a tag FIFO, then routes each sorter result back to the requester that owns it, in order.
- Sits between the packet front-ends and a single sorter instance.

---
 rtl/sort_arbiter_if.sv | 38 +++
 rtl/sort_arbiter.sv | 141 ++++++++++++++
 tb/tb_sort_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sort_arbiter_if.sv
// Requester-side and sorter-side stream signals of the sort arbiter.
// A beat transfers on any cycle where tvalid and tready are both high; a source holds tvalid and data stable until then.
interface sort_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int NUM_ELEMS  = 16,
   parameter int DATA_WIDTH = 8
);
   localparam int VEC_W = NUM_ELEMS * DATA_WIDTH;

   logic [NUM_REQ-1:0]       req_tvalid;
   logic [NUM_REQ-1:0]       req_tready;
   logic [NUM_REQ*VEC_W-1:0] req_tdata_raw;
   logic [NUM_REQ-1:0]       rsp_tvalid;
   logic [NUM_REQ-1:0]       rsp_tready;
   logic [VEC_W-1:0]         rsp_tdata_raw;
   logic                     srt_src_tvalid;
   logic                     srt_src_tready;
   logic [VEC_W-1:0]         srt_src_tdata_raw;
   logic                     srt_dest_tvalid;
   logic                     srt_dest_tready;
   logic [VEC_W-1:0]         srt_dest_tdata_raw;

   // The arbiter itself.
   modport slave (
      input  req_tvalid, req_tdata_raw, rsp_tready,
      input  srt_src_tready, srt_dest_tvalid, srt_dest_tdata_raw,
      output req_tready, rsp_tvalid, rsp_tdata_raw,
      output srt_src_tvalid, srt_src_tdata_raw, srt_dest_tready
   );

   // The surroundings: requester front-ends plus the sorter.
   modport master (
      output req_tvalid, req_tdata_raw, rsp_tready,
      output srt_src_tready, srt_dest_tvalid, srt_dest_tdata_raw,
      input  req_tready, rsp_tvalid, rsp_tdata_raw,
      input  srt_src_tvalid, srt_src_tdata_raw, srt_dest_tready
   );
endinterface

// File: rtl/sort_arbiter.sv
// Round-robin sharing of one vector sorter between NUM_REQ requesters;
// a tag FIFO remembers who owns each in-flight job so results route back in order.
module sort_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int NUM_ELEMS    = 16,
   parameter int DATA_WIDTH   = 8,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   sort_arbiter_if.slave                       bus,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
   output logic                                orphan_err,
   output logic                                arb_state
);
   localparam int VEC_W = NUM_ELEMS * DATA_WIDTH;
   localparam int GW    = $clog2(NUM_REQ);
   localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

   localparam logic [GW-1:0]    RR_LAST  = GW'(NUM_REQ - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_INFLIGHT - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_INFLIGHT);

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   arb_state_t       state, state_next;
   logic [GW-1:0]    grant, grant_next;
   logic [GW-1:0]    rr_ptr, rr_next;
   logic [GW-1:0]    pick;
   logic             pick_found;
   logic             push, pop;
   logic             fifo_full, fifo_empty;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [GW-1:0]    tag_mem [MAX_INFLIGHT];
   logic [GW-1:0]    head;

   assign fifo_full  = (inflight == FULL_CNT);
   assign fifo_empty = (inflight == '0);
   assign arb_state  = logic'(state);

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick       = rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         int unsigned idx;
         idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (!pick_found && bus.req_tvalid[idx]) begin
            pick_found = 1'b1;
            pick       = GW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ARB_IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_next;
         grant  <= grant_next;
         rr_ptr <= rr_next;
      end
   end

   always_comb begin
      state_next         = state;
      grant_next         = grant;
      rr_next            = rr_ptr;
      push               = 1'b0;
      bus.srt_src_tvalid = 1'b0;
      bus.req_tready     = '0;
      case (state)
         ARB_IDLE: begin
            // Full is judged on the registered count, so a same-cycle pop does not open a slot.
            if (!fifo_full && pick_found) begin
               grant_next = pick;
               state_next = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            bus.srt_src_tvalid    = 1'b1;
            bus.req_tready[grant] = bus.srt_src_tready;
            if (bus.srt_src_tready) begin
               push       = 1'b1;
               rr_next    = (grant == RR_LAST) ? '0 : grant + 1'b1;
               state_next = ARB_IDLE;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   assign bus.srt_src_tdata_raw = bus.req_tdata_raw[grant*VEC_W +: VEC_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= grant;
   end

   assign head = tag_mem[rd_ptr];

   // Results route only to the owner of the oldest outstanding job.
   always_comb begin
      bus.rsp_tvalid      = '0;
      bus.srt_dest_tready = 1'b0;
      if (!fifo_empty) begin
         bus.rsp_tvalid[head] = bus.srt_dest_tvalid;
         bus.srt_dest_tready  = bus.rsp_tready[head];
      end
   end

   assign pop               = bus.srt_dest_tvalid & bus.srt_dest_tready;
   assign bus.rsp_tdata_raw = bus.srt_dest_tdata_raw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   orphan_err <= 1'b0;
      else if (fifo_empty && bus.srt_dest_tvalid) orphan_err <= 1'b1;
   end

endmodule

// File: tb/tb_sort_arbiter.sv
// Directed bench for sort_arbiter: cycle table of inputs/expected outputs,
// then hand sequences for orphan results and asynchronous reset mid-grant.
module tb_sort_arbiter;
   localparam int NR = 4;
   localparam int NE = 16;
   localparam int DW = 8;
   localparam int MI = 4;
   localparam int VW = NE * DW;

   logic       clk;
   logic       rst;
   logic [2:0] inflight;
   logic       orphan_err;
   logic       arb_state;

   int n_cmp = 0;
   int n_bad = 0;

   logic [VW-1:0] slice_q [NR];
   logic [VW-1:0] dest_data;

   typedef struct {
      logic [3:0] req_v;
      logic       src_rdy;
      logic       dst_v;
      logic [3:0] rsp_rdy;
      logic       e_src_v;
      logic [3:0] e_req_rdy;
      logic [3:0] e_rsp_v;
      logic       e_dst_rdy;
      logic [2:0] e_inflight;
      int         e_grant;
   } step_t;

   step_t steps[$];

   sort_arbiter_if #(.NUM_REQ(NR), .NUM_ELEMS(NE), .DATA_WIDTH(DW)) bus ();

   sort_arbiter #(
      .NUM_REQ(NR), .NUM_ELEMS(NE), .DATA_WIDTH(DW), .MAX_INFLIGHT(MI)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .inflight   (inflight),
      .orphan_err (orphan_err),
      .arb_state  (arb_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [3:0] req_v, input logic src_rdy, input logic dst_v,
                               input logic [3:0] rsp_rdy, input logic e_src_v,
                               input logic [3:0] e_req_rdy, input logic [3:0] e_rsp_v,
                               input logic e_dst_rdy, input logic [2:0] e_inflight, input int e_grant);
      step_t s;
      s = '{req_v, src_rdy, dst_v, rsp_rdy, e_src_v, e_req_rdy, e_rsp_v, e_dst_rdy, e_inflight, e_grant};
      steps.push_back(s);
   endfunction

   initial begin
      for (int r = 0; r < NR; r++) begin
         for (int e = 0; e < NE; e++)
            slice_q[r][e*DW +: DW] = 8'(r * 16 + ((e * 7 + 3) % 16));
         bus.req_tdata_raw[r*VW +: VW] = slice_q[r];
      end
      rst                    = 1'b1;
      bus.req_tvalid         = '0;
      bus.rsp_tready         = '0;
      bus.srt_src_tready     = 1'b0;
      bus.srt_dest_tvalid    = 1'b0;
      bus.srt_dest_tdata_raw = '0;

      // Single job to requester 2
      add(4'b0100, 0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
      add(4'b0100, 0, 0, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 2);
      add(4'b0100, 1, 0, 4'b1111, 1, 4'b0100, 4'b0000, 0, 0, 2);
      add(4'b0000, 0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 1, 1, 0);
      add(4'b0000, 0, 1, 4'b1111, 0, 4'b0000, 4'b0100, 1, 1, 0);
      add(4'b0000, 0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
      // Fairness from rr_ptr=3 with all requesting, filling the tag FIFO
      add(4'b1111, 1, 0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
      add(4'b1111, 1, 0, 4'b1111, 1, 4'b1000, 4'b0000, 0, 0, 3);
      add(4'b1111, 1, 0, 4'b1111, 0, 4'b0000, 4'b0000, 1, 1, 0);
      add(4'b1111, 1, 0, 4'b1111, 1, 4'b0001, 4'b0000, 1, 1, 0);
      add(4'b1111, 1, 0, 4'b1111, 0, 4'b0000, 4'b0000, 1, 2, 0);
      add(4'b1111, 1, 0, 4'b1111, 1, 4'b0010, 4'b0000, 1, 2, 1);
      add(4'b1111, 1, 0, 4'b1111, 0, 4'b0000, 4'b0000, 1, 3, 0);
      add(4'b1111, 1, 0, 4'b1111, 1, 4'b0100, 4'b0000, 1, 3, 2);
      // Full: no grant, not even on the pop cycle
      add(4'b1111, 1, 0, 4'b1111, 0, 4'b0000, 4'b0000, 1, 4, 0);
      add(4'b1111, 1, 0, 4'b1111, 0, 4'b0000, 4'b0000, 1, 4, 0);
      add(4'b1111, 1, 1, 4'b1111, 0, 4'b0000, 4'b1000, 1, 4, 0);
      add(4'b1111, 1, 0, 4'b1111, 0, 4'b0000, 4'b0000, 1, 3, 0);
      add(4'b1111, 1, 0, 4'b1111, 1, 4'b1000, 4'b0000, 1, 3, 3);
      // Drain 0,1,2,3 in order with requester 1 stalling
      add(4'b0000, 0, 1, 4'b1111, 0, 4'b0000, 4'b0001, 1, 4, 0);
      add(4'b0000, 0, 1, 4'b1101, 0, 4'b0000, 4'b0010, 0, 3, 0);
      add(4'b0000, 0, 1, 4'b1101, 0, 4'b0000, 4'b0010, 0, 3, 0);
      add(4'b0000, 0, 1, 4'b1111, 0, 4'b0000, 4'b0010, 1, 3, 0);
      add(4'b0000, 0, 1, 4'b1111, 0, 4'b0000, 4'b0100, 1, 2, 0);
      add(4'b0000, 0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 1, 1, 0);
      add(4'b0000, 0, 1, 4'b1111, 0, 4'b0000, 4'b1000, 1, 1, 0);
      add(4'b0000, 0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
      // Simultaneous push and pop
      add(4'b0001, 0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
      add(4'b0001, 1, 0, 4'b1111, 1, 4'b0001, 4'b0000, 0, 0, 0);
      add(4'b0010, 0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 1, 1, 0);
      add(4'b0010, 1, 1, 4'b1111, 1, 4'b0010, 4'b0001, 1, 1, 1);
      add(4'b0000, 0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 1, 1, 0);
      add(4'b0000, 0, 1, 4'b1111, 0, 4'b0000, 4'b0010, 1, 1, 0);
      add(4'b0000, 0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);

      // Reset values, no clock edge yet
      #3;
      check("rst_src_v", VW'(bus.srt_src_tvalid), VW'(1'b0));
      check("rst_req_rdy", VW'(bus.req_tready), VW'(4'b0000));
      check("rst_rsp_v", VW'(bus.rsp_tvalid), VW'(4'b0000));
      check("rst_dst_rdy", VW'(bus.srt_dest_tready), VW'(1'b0));
      check("rst_inflight", VW'(inflight), VW'(3'd0));
      check("rst_orphan", VW'(orphan_err), VW'(1'b0));
      check("rst_state", VW'(arb_state), VW'(1'b0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (steps[i]) begin
         bus.req_tvalid         = steps[i].req_v;
         bus.srt_src_tready     = steps[i].src_rdy;
         bus.srt_dest_tvalid    = steps[i].dst_v;
         bus.rsp_tready         = steps[i].rsp_rdy;
         dest_data              = {$urandom, $urandom, $urandom, $urandom};
         bus.srt_dest_tdata_raw = dest_data;
         #1;
         check($sformatf("s%0d_src_v", i), VW'(bus.srt_src_tvalid), VW'(steps[i].e_src_v));
         check($sformatf("s%0d_req_rdy", i), VW'(bus.req_tready), VW'(steps[i].e_req_rdy));
         check($sformatf("s%0d_rsp_v", i), VW'(bus.rsp_tvalid), VW'(steps[i].e_rsp_v));
         check($sformatf("s%0d_dst_rdy", i), VW'(bus.srt_dest_tready), VW'(steps[i].e_dst_rdy));
         check($sformatf("s%0d_inflight", i), VW'(inflight), VW'(steps[i].e_inflight));
         check($sformatf("s%0d_rsp_data", i), bus.rsp_tdata_raw, dest_data);
         if (steps[i].e_src_v)
            check($sformatf("s%0d_src_data", i), bus.srt_src_tdata_raw, slice_q[steps[i].e_grant]);
         tick();
      end
      check("tbl_orphan", VW'(orphan_err), VW'(1'b0));

      // Orphan result while the tag FIFO is empty
      bus.srt_dest_tvalid = 1'b1;
      #1;
      check("orph_dst_rdy", VW'(bus.srt_dest_tready), VW'(1'b0));
      check("orph_rsp_v", VW'(bus.rsp_tvalid), VW'(4'b0000));
      tick();
      check("orph_set", VW'(orphan_err), VW'(1'b1));
      bus.srt_dest_tvalid = 1'b0;
      repeat (3) tick();
      check("orph_sticky", VW'(orphan_err), VW'(1'b1));
      check("orph_inflight", VW'(inflight), VW'(3'd0));

      // Two accepts (grants 2 then 3), then hold a grant on requester 0
      bus.req_tvalid     = 4'b1111;
      bus.srt_src_tready = 1'b1;
      repeat (4) tick();
      check("mid_inflight", VW'(inflight), VW'(3'd2));
      bus.srt_src_tready = 1'b0;
      tick();
      check("mid_src_v", VW'(bus.srt_src_tvalid), VW'(1'b1));
      check("mid_src_data", bus.srt_src_tdata_raw, slice_q[0]);

      // Asynchronous reset between clock edges
      #2;
      rst = 1'b1;
      #1;
      check("arst_src_v", VW'(bus.srt_src_tvalid), VW'(1'b0));
      check("arst_inflight", VW'(inflight), VW'(3'd0));
      check("arst_orphan", VW'(orphan_err), VW'(1'b0));
      check("arst_req_rdy", VW'(bus.req_tready), VW'(4'b0000));
      check("arst_state", VW'(arb_state), VW'(1'b0));
      #1;
      bus.req_tvalid = 4'b0110;
      rst            = 1'b0;
      tick();
      check("post_src_v", VW'(bus.srt_src_tvalid), VW'(1'b1));
      check("post_src_data", bus.srt_src_tdata_raw, slice_q[1]);
      bus.srt_src_tready = 1'b1;
      #1;
      check("post_req_rdy", VW'(bus.req_tready), VW'(4'b0010));
      tick();
      check("post_inflight", VW'(inflight), VW'(3'd1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
